// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: round-robin sharing of the single-port ID ROM between
// the user-ID lookup controller (requester 0) and the password lookup
// controller (requester 1). One ROM read per grant. The nibble comes back to
// the winner with a one-cycle valid strobe after the ROM's fixed latency.
module rom_access_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              valid0,
  output logic              valid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
);

  // The wait counter only has to reach ROM_LAT-1.
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wcnt, wcnt_nxt;
  logic              owner, owner_nxt;
  logic              last, last_nxt;
  logic              sel;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              gnt0_nxt, gnt1_nxt;
  logic              valid0_nxt, valid1_nxt;

  // Requester choice: a lone request wins outright; under contention the
  // requester that was not served last wins, so grants alternate.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) begin
      sel = ~last;
    end else if (req1) begin
      sel = 1'b1;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    owner_nxt  = owner;
    last_nxt   = last;
    addr_nxt   = rom_addr;
    rdata_nxt  = rdata;
    gnt0_nxt   = 1'b0;
    gnt1_nxt   = 1'b0;
    valid0_nxt = 1'b0;
    valid1_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // Address is captured only from the selected requester.
          owner_nxt = sel;
          addr_nxt  = sel ? addr1 : addr0;
          gnt0_nxt  = ~sel;
          gnt1_nxt  = sel;
          wcnt_nxt  = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Stays here exactly ROM_LAT cycles while the ROM pipeline fills.
        wcnt_nxt = wcnt + 1'b1;
        if (wcnt == LAST_CNT) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        rdata_nxt  = rom_q;
        valid0_nxt = ~owner;
        valid1_nxt = owner;
        last_nxt   = owner;
        state_nxt  = S_IDLE;
      end
      default: begin
        // Unreachable encoding: fall back to idle reset values, keeping the
        // fairness pointer so recovery does not bias the next contention.
        state_nxt = S_IDLE;
        wcnt_nxt  = '0;
        owner_nxt = 1'b0;
        addr_nxt  = '0;
        rdata_nxt = '0;
      end
    endcase
  end

  // State register and registered outputs; reset discards any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      rom_addr <= '0;
      rdata    <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      valid0   <= 1'b0;
      valid1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      rom_addr <= addr_nxt;
      rdata    <= rdata_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      valid0   <= valid0_nxt;
      valid1   <= valid1_nxt;
    end
  end

  // A read is outstanding whenever the arbiter has left IDLE.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a registered-address,
// registered-output ROM model of latency 2.
module tb_rom_access_arbiter;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 4;
  localparam int ROM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1, valid0, valid1, busy;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;

  logic [DATA_W-1:0] mem [0:31];
  logic [ADDR_W-1:0] rom_addr_r;

  int n_chk = 0;
  int n_err = 0;

  rom_access_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .addr0   (addr0),
    .req1    (req1),
    .addr1   (addr1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .valid0  (valid0),
    .valid1  (valid1),
    .rdata   (rdata),
    .busy    (busy),
    .rom_addr(rom_addr),
    .rom_q   (rom_q)
  );

  always #5 clk = ~clk;

  // ROM model: address registered on one edge, data on the next.
  always @(posedge clk) begin
    rom_addr_r <= rom_addr;
    rom_q      <= mem[rom_addr_r];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {gnt0, gnt1, valid0, valid1}
  function automatic logic [31:0] ctl();
    return 32'({gnt0, gnt1, valid0, valid1});
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({gnt0, gnt1, valid0, valid1, busy, rdata, rom_addr});
  endfunction

  logic [3:0] exp_ctl;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 4'(i);
    mem[5] = 4'hA;
    mem[1] = 4'h3;
    mem[2] = 4'h7;
    mem[4] = 4'hC;
    mem[9] = 4'h1;

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

    // Reset held with random requests.
    for (int c = 0; c < 6; c++) begin
      req0  = 1'($urandom_range(0, 1));
      req1  = 1'($urandom_range(0, 1));
      addr0 = 5'($urandom_range(0, 31));
      addr1 = 5'($urandom_range(0, 31));
      tick();
      chk("reset_hold", all_out(), 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    #2 rst = 1'b1;

    // Single read from requester 0.
    tick();
    req0 = 1'b1; addr0 = 5'd5;
    tick();
    chk("single_gnt", ctl(), 32'b1000);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_addr", 32'(rom_addr), 32'd5);
    req0 = 1'b0; addr0 = 5'd17;
    tick();
    chk("single_c1", ctl(), 32'b0000);
    tick();
    chk("single_c2", ctl(), 32'b0000);
    tick();
    chk("single_valid", ctl(), 32'b0010);
    chk("single_rdata", 32'(rdata), 32'hA);
    chk("single_busy_fall", 32'(busy), 32'd0);
    tick();
    chk("single_after", ctl(), 32'b0000);

    // Reset again so requester 0 wins the first contention.
    #2 rst = 1'b0;
    #1 chk("reset_async", all_out(), 32'd0);
    #2 rst = 1'b1;

    // Continuous contention: strict alternation, 4-cycle spacing.
    req0 = 1'b1; addr0 = 5'd1;
    req1 = 1'b1; addr1 = 5'd2;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_ctl = 4'b0000;
        if (c == 0) exp_ctl = (k % 2 == 0) ? 4'b1000 : 4'b0100;
        if (c == 3) exp_ctl = (k % 2 == 0) ? 4'b0010 : 4'b0001;
        chk($sformatf("cont_t%0d_c%0d", k, c), ctl(), 32'(exp_ctl));
        if (c == 0) chk($sformatf("cont_addr%0d", k), 32'(rom_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
        if (c == 3) chk($sformatf("cont_rdata%0d", k), 32'(rdata), (k % 2 == 0) ? 32'd3 : 32'd7);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("cont_idle", ctl(), 32'b0000);

    // Address change and request drop while the read is in flight.
    req1 = 1'b1; addr1 = 5'd4;
    tick();
    chk("chg_gnt", ctl(), 32'b0100);
    tick();
    addr1 = 5'd9; req1 = 1'b0;
    tick();
    chk("chg_c2", ctl(), 32'b0000);
    tick();
    chk("chg_valid", ctl(), 32'b0001);
    chk("chg_rdata", 32'(rdata), 32'hC);
    chk("chg_addr", 32'(rom_addr), 32'd4);

    // Reset pulsed during WAIT discards the read.
    req0 = 1'b1; addr0 = 5'd2;
    tick();
    chk("mid_gnt", ctl(), 32'b1000);
    req0 = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk("mid_async", all_out(), 32'd0);
    #2 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid_quiet", 32'({gnt0, gnt1, valid0, valid1, busy}), 32'd0);
    end
    req0 = 1'b1; addr0 = 5'd5;
    tick();
    chk("fresh_gnt", ctl(), 32'b1000);
    req0 = 1'b0;
    tick();
    chk("fresh_c1", ctl(), 32'b0000);
    tick();
    chk("fresh_c2", ctl(), 32'b0000);
    tick();
    chk("fresh_valid", ctl(), 32'b0010);
    chk("fresh_rdata", 32'(rdata), 32'hA);

    // Idle hold: address and data keep their last values.
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_hold", all_out(), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 5'd5}));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Shares the single-port ID ROM (`ID_rom`, registered address and registered output) between two requesters: the user-ID lookup controller and the password lookup controller. The block arbitrates round-robin, issues one ROM read per grant, waits the ROM's fixed read latency, then returns the nibble to the winning requester with a one-cycle valid strobe. It sits between the two controllers and the ROM instance, and replaces direct ROM address drive by either controller.

## Interface
Parameters:
- ADDR_W, 5, ROM address width.
- DATA_W, 4, ROM data width.
- ROM_LAT, 2, ROM read latency in clocks, counted from the edge that registers `rom_addr` to the edge that registers `rom_q`. Must be ≥1.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 (user-ID controller) read request, level.
- addr0  in  ADDR_W  requester 0 read address, sampled at grant.
- req1  in  1  requester 1 (password controller) read request, level.
- addr1  in  ADDR_W  requester 1 read address, sampled at grant.
- gnt0, gnt1  out  1  one-cycle grant pulse; address accepted.
- valid0, valid1  out  1  one-cycle read-data strobe to the owner.
- rdata  out  DATA_W  read data; holds until the next capture.
- busy  out  1  high while a read is outstanding (state ≠ IDLE).
- rom_addr  out  ADDR_W  address to ROM.
- rom_q  in  DATA_W  ROM read data.

## Operation
- States: IDLE, WAIT, CAPTURE.
- IDLE: if no req, stay and drive gnt/valid low. If exactly one req is high, select it. If both are high, select the requester not served last (`last` pointer). On that edge: `rom_addr` ← selected addr, `owner` ← selected, gnt_owner ← 1, `wcnt` ← 0, go to WAIT.
- WAIT: gnt low. `wcnt` increments each edge. When `wcnt == ROM_LAT-1`, go to CAPTURE. WAIT lasts exactly ROM_LAT cycles.
- CAPTURE: `rdata` ← `rom_q`, valid_owner ← 1, `last` ← owner, go to IDLE.
- Handshake: a req that is high on any IDLE edge starts a new read. The requester must drop req, or present its next address, within ROM_LAT+1 cycles after seeing gnt, that is, before the arbiter returns to IDLE.
- Changes to req or addr after the grant edge do not affect the read in flight. A req dropped after grant still completes with valid.
- Fairness: under continuous contention, grants strictly alternate. No requester waits more than one transaction.
- `rom_addr` holds its last value between reads. It is never driven from an unselected requester.
- Reset (rst low, asynchronous, effective immediately without a clock): state ← IDLE; gnt0, gnt1, valid0, valid1, busy ← 0; rdata ← 0; rom_addr ← 0; wcnt ← 0; `last` ← 1, so req0 wins the first contention. An in-flight read is discarded, and no valid is produced for it after rst releases.
- Default/illegal state: recover to IDLE with reset values, except `last`, which is unchanged.

## Timing
- Edge E0, IDLE samples a req: gnt high during cycle E0→E1, busy high from E0.
- ROM registers the address at E1 and its output at E0+ROM_LAT.
- CAPTURE edge is E0+ROM_LAT+1: valid and rdata are updated there, and busy falls there.
- Grant-to-valid latency is ROM_LAT+1 cycles (3 at default).
- Next grant is possible at the edge after CAPTURE, E0+ROM_LAT+2.
- Throughput is one read per ROM_LAT+2 cycles (4 at default).
- valid and gnt are never high together. At most one of gnt0/gnt1 and one of valid0/valid1 is high in any cycle.
- Valid is produced only in CAPTURE, only for `owner`.

## Test plan
- Reset: hold rst low with random reqs and clock → all outputs 0, rom_addr=0. Assert rst low between clock edges → outputs clear before the next edge.
- Single read: ROM model mem[5]=4'hA, req0 high with addr0=5 at E0 → gnt0 in cycle E0, rom_addr=5, valid0 exactly 3 cycles after gnt0, rdata=4'hA, valid1 never high.
- Contention after reset: req0 and req1 held high, addr0=1 (mem=3), addr1=2 (mem=7) → grant order gnt0, gnt1, gnt0, gnt1 at 4-cycle spacing, with rdata 3, 7, 3, 7 on the matching valid.
- Address change in flight: req1 with addr1=4 (mem=4'hC), then addr1 changed to 9 and req1 dropped the cycle after gnt1 → valid1 still fires, rdata=4'hC.
- Reset mid-read: rst pulsed low during WAIT → immediate clear, no valid0/valid1 after release. A fresh req0 then completes normally with 3-cycle latency.
- Idle hold: no req for 20 cycles after a read → busy=0, rom_addr and rdata hold their last values, gnt and valid stay low.
